// File: rtl/rv_dec_pkg.sv
// Shared decode definitions for the RV32I instruction-decode stage:
// opcode/funct constants, ALU operation codes and control-word bit positions.
package rv_dec_pkg;

  localparam int CTRL_W = 13;

  // Major opcodes understood by the decoder
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_MUL     = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operation encoding carried in out_ctrl[3:0]
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SLL = 4'd1,
    ALU_SLT = 4'd2,
    ALU_MUL = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SRL = 4'd5,
    ALU_OR  = 4'd6,
    ALU_AND = 4'd7,
    ALU_SUB = 4'd8,
    ALU_SRA = 4'd13
  } alu_op_e;

  // Control-word bit positions
  localparam int CTRL_ALU_SRC_IMM = 4;
  localparam int CTRL_REG_WRITE   = 5;
  localparam int CTRL_MEM_TO_REG  = 6;
  localparam int CTRL_MEM_WRITE   = 7;
  localparam int CTRL_MEM_READ    = 8;
  localparam int CTRL_BRANCH      = 9;
  localparam int CTRL_JALR        = 10;
  localparam int CTRL_JAL         = 11;
  localparam int CTRL_BRANCH_NE   = 12;

  // Loads: mem_read, mem_to_reg, reg_write, alu_src_imm (bits [8:4])
  localparam logic [4:0] LOAD_FLAGS = 5'h17;

  // True for the load widths RV32I defines (LB, LH, LW, LBU, LHU)
  function automatic logic is_load_width(logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/id_pipe_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
interface id_pipe_stage_if
  import rv_dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_imm;
  logic [PC_W-1:0]   out_pc;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic              out_illegal;

  // Environment side: fetch drives the request, execute drives ready/flush
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_imm, out_pc,
           out_rs1, out_rs2, out_rd, out_illegal
  );

  // Decode-stage side
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_imm, out_pc,
           out_rs1, out_rs2, out_rd, out_illegal
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I(+MUL) decoder: instruction word to control word,
// sign-extended immediate, illegal flag and source-register usage.
module rv_decode_comb
  import rv_dec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   imm,
  output logic              illegal,
  output logic              uses_rs1,
  output logic              uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [CTRL_W-1:0]  ctrl_raw;
  alu_op_e            alu;
  logic               legal;
  logic signed [31:0] imm32;

  // Select format, flags and ALU op; an unrecognised encoding zeroes the control word
  always_comb begin
    ctrl_raw = '0;
    alu      = ALU_ADD;
    legal    = 1'b0;
    imm32    = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ctrl_raw[CTRL_REG_WRITE] = 1'b1;
        legal = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: alu = ALU_ADD;
            F3_SLL:     alu = ALU_SLL;
            F3_SLT:     alu = ALU_SLT;
            F3_XOR:     alu = ALU_XOR;
            F3_SRL_SRA: alu = ALU_SRL;
            F3_OR:      alu = ALU_OR;
            F3_AND:     alu = ALU_AND;
            default:    legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            F3_ADD_SUB: alu = ALU_SUB;
            F3_SRL_SRA: alu = ALU_SRA;
            default:    legal = 1'b0;
          endcase
        end else if (funct7 == F7_MULDIV && funct3 == F3_MUL && ENABLE_M != 0) begin
          alu = ALU_MUL;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        imm32    = imm_i;
        ctrl_raw[CTRL_REG_WRITE]   = 1'b1;
        ctrl_raw[CTRL_ALU_SRC_IMM] = 1'b1;
        legal = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu = ALU_ADD;
          F3_SLT:     alu = ALU_SLT;
          F3_XOR:     alu = ALU_XOR;
          F3_OR:      alu = ALU_OR;
          F3_AND:     alu = ALU_AND;
          F3_SLL: begin
            if (funct7 == F7_BASE) alu = ALU_SLL;
            else                   legal = 1'b0;
          end
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE)     alu = ALU_SRL;
            else if (funct7 == F7_ALT) alu = ALU_SRA;
            else                       legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        imm32    = imm_i;
        ctrl_raw[8:4] = LOAD_FLAGS;
        legal = is_load_width(funct3);
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = imm_s;
        ctrl_raw[CTRL_MEM_WRITE]   = 1'b1;
        ctrl_raw[CTRL_ALU_SRC_IMM] = 1'b1;
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = imm_b;
        ctrl_raw[CTRL_BRANCH]    = 1'b1;
        ctrl_raw[CTRL_BRANCH_NE] = (funct3 == F3_BNE);
        legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      end
      OPC_JALR: begin
        uses_rs1 = 1'b1;
        imm32    = imm_i;
        ctrl_raw[CTRL_JALR]      = 1'b1;
        ctrl_raw[CTRL_REG_WRITE] = 1'b1;
        legal = (funct3 == F3_JALR);
      end
      OPC_JAL: begin
        imm32 = imm_j;
        ctrl_raw[CTRL_JAL]       = 1'b1;
        ctrl_raw[CTRL_REG_WRITE] = 1'b1;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    ctrl_raw[3:0] = alu;
  end

  assign ctrl    = legal ? ctrl_raw : '0;
  assign illegal = ~legal;
  assign imm     = XLEN'(imm32);

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage: owns the ID/EX register, the valid/ready
// handshake, the load-use bubble and the flush from execute.
module id_pipe_stage
  import rv_dec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_W     = 32,
  parameter int ENABLE_M = 0
) (
  input logic           clk,
  input logic           rst_n,
  id_pipe_stage_if.slave bus
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;

  rv_decode_comb #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr    (bus.in_instr),
    .ctrl     (dec_ctrl),
    .imm      (dec_imm),
    .illegal  (dec_illegal),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic [4:0] in_rd;

  assign in_rs1 = bus.in_instr[19:15];
  assign in_rs2 = bus.in_instr[24:20];
  assign in_rd  = bus.in_instr[11:7];

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   imm_q;
  logic [PC_W-1:0]   pc_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [4:0]        rd_q;
  logic              illegal_q;

  // Load-use detection looks only at the presented instruction word, never at
  // in_valid, so in_ready has no combinational path from in_valid.
  logic load_in_ex;
  logic src_match;
  logic load_use;
  logic in_ready;
  logic accept;

  assign load_in_ex = valid_q & ctrl_q[CTRL_MEM_READ] & (rd_q != 5'd0);
  assign src_match  = (dec_uses_rs1 & (in_rs1 == rd_q)) |
                      (dec_uses_rs2 & (in_rs2 == rd_q));
  assign load_use   = load_in_ex & bus.out_ready & src_match;
  assign in_ready   = rst_n & ~bus.flush & ~load_use & (~valid_q | bus.out_ready);
  assign accept     = bus.in_valid & in_ready;

  // ID/EX register: flush kills, accept loads, consumption without refill empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      ctrl_q    <= dec_ctrl;
      imm_q     <= dec_imm;
      pc_q      <= bus.in_pc;
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      rd_q      <= in_rd;
      illegal_q <= dec_illegal;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_ctrl    = ctrl_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_rs1     = rs1_q;
  assign bus.out_rs2     = rs2_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = illegal_q;

endmodule
